// File: rtl/mul_pkg.sv
// Shared types and parameter legality helpers for the sequential multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // WIDTH must be at least 2; BPC must be 1, 2 or 4 and divide WIDTH evenly.
    function automatic bit params_ok(input int unsigned width, input int unsigned bpc);
        return (width >= 2) && ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mul_seq_p_if.sv
// Request/result bundle between an issuing datapath and the sequential multiplier.
interface mul_seq_p_if #(
    parameter int unsigned WIDTH = 8
);
    logic               start;
    logic               sgn;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] O;
    logic               fin;
    logic               busy;

    modport master (output start, sgn, A, B, input O, fin, busy);
    modport slave  (input start, sgn, A, B, output O, fin, busy);
endinterface

// File: rtl/mul_pp.sv
// Partial product of the multiplicand magnitude and one BPC-bit multiplier digit.
module mul_pp #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [BPC-1:0]       d,
    output logic [WIDTH+BPC-1:0] pp
);
    localparam int unsigned PW = WIDTH + BPC;

    assign pp = PW'(a) * PW'(d);
endmodule

// File: rtl/mul_seq_p.sv
// Iterative multiplier retiring BPC multiplier bits per cycle; signed operands are
// multiplied as magnitudes and the sign is restored in a final fixup cycle.
module mul_seq_p
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic       ck,
    input  logic       rst,
    mul_seq_p_if.slave bus
);
    localparam int unsigned N  = WIDTH / BPC;
    localparam int unsigned PW = WIDTH + BPC;
    localparam int unsigned OW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(N + 1);

    if (!params_ok(WIDTH, BPC)) begin : g_bad_params
        $error("mul_seq_p: WIDTH must be >= 2 and BPC in {1,2,4} dividing WIDTH");
    end

    state_t           state;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_sh;
    logic             neg;
    logic [OW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic [OW-1:0]    prod;
    logic             fin_q;
    logic             busy_q;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [PW-1:0]    pp;
    logic [OW-1:0]    pp_sh;
    logic             last;

    // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is exact as unsigned.
    assign a_abs = (bus.sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_abs = (bus.sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    mul_pp #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_pp (
        .a  (a_mag),
        .d  (b_sh[BPC-1:0]),
        .pp (pp)
    );

    assign pp_sh = OW'(pp) << (BPC * 32'(cnt));
    assign last  = (cnt == CW'(N - 1));

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_mag  <= '0;
            b_sh   <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            prod   <= '0;
            fin_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            fin_q <= (state == DONE);
            if (state == DONE) begin
                prod <= neg ? -acc : acc;
            end

            if (state == CALC) begin
                acc  <= acc + pp_sh;
                b_sh <= b_sh >> BPC;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    state <= DONE;
                end
            end else if (bus.start) begin
                // Accepted from IDLE or on the DONE edge (back-to-back issue).
                state  <= CALC;
                a_mag  <= a_abs;
                b_sh   <= b_abs;
                neg    <= bus.sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                acc    <= '0;
                cnt    <= '0;
                busy_q <= 1'b1;
            end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.O    = prod;
    assign bus.fin  = fin_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mul_seq_p.sv
// Drives three 8-bit multipliers (BPC 1, 2, 4) with shared stimulus and checks each
// against a cycle-level countdown model of the issue/complete protocol.
module tb_mul_seq_p;
    logic       ck    = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       sgn   = 1'b0;
    logic [7:0] a     = 8'd0;
    logic [7:0] b     = 8'd0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 ck = ~ck;

    mul_seq_p_if #(.WIDTH(8)) bus1 ();
    mul_seq_p_if #(.WIDTH(8)) bus2 ();
    mul_seq_p_if #(.WIDTH(8)) bus4 ();

    assign bus1.start = start;
    assign bus1.sgn   = sgn;
    assign bus1.A     = a;
    assign bus1.B     = b;
    assign bus2.start = start;
    assign bus2.sgn   = sgn;
    assign bus2.A     = a;
    assign bus2.B     = b;
    assign bus4.start = start;
    assign bus4.sgn   = sgn;
    assign bus4.A     = a;
    assign bus4.B     = b;

    mul_seq_p #(.WIDTH(8), .BPC(1)) dut1 (.ck(ck), .rst(rst), .bus(bus1));
    mul_seq_p #(.WIDTH(8), .BPC(2)) dut2 (.ck(ck), .rst(rst), .bus(bus2));
    mul_seq_p #(.WIDTH(8), .BPC(4)) dut4 (.ck(ck), .rst(rst), .bus(bus4));

    function automatic logic [15:0] ref_product(input logic s, input logic [7:0] x, input logic [7:0] y);
        int xi;
        int yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        return 16'(xi * yi);
    endfunction

    // Model per lane: m_rem counts edges until the result appears (0 = idle).
    // Lane l has N = 8 >> l, so a result appears N+1 edges after acceptance.
    int          m_rem  [3];
    logic [15:0] m_pend [3];
    logic [15:0] m_o    [3];
    logic        m_fin  [3];
    logic        m_busy [3];

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 3; l++) begin
                m_rem[l]  <= 0;
                m_pend[l] <= 16'd0;
                m_o[l]    <= 16'd0;
                m_fin[l]  <= 1'b0;
                m_busy[l] <= 1'b0;
            end
        end else begin
            for (int l = 0; l < 3; l++) begin
                m_fin[l]  <= (m_rem[l] == 1);
                m_o[l]    <= (m_rem[l] == 1) ? m_pend[l] : m_o[l];
                m_busy[l] <= (m_rem[l] > 1) || ((m_rem[l] <= 1) && start);
                m_rem[l]  <= ((m_rem[l] <= 1) && start) ? (8 >> l) + 1 :
                             (m_rem[l] > 0) ? m_rem[l] - 1 : 0;
                if ((m_rem[l] <= 1) && start) begin
                    m_pend[l] <= ref_product(sgn, a, b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lane_check(input string tag, input logic [15:0] o, input logic f,
                              input logic bz, input int l);
        check({tag, "_O"},    32'(o),  32'(m_o[l]));
        check({tag, "_fin"},  32'(f),  32'(m_fin[l]));
        check({tag, "_busy"}, 32'(bz), 32'(m_busy[l]));
    endtask

    task automatic lane_zero(input string tag, input logic [15:0] o, input logic f, input logic bz);
        check({tag, "_O_rst"},    32'(o),  32'd0);
        check({tag, "_fin_rst"},  32'(f),  32'd0);
        check({tag, "_busy_rst"}, 32'(bz), 32'd0);
    endtask

    // Advance to the next falling edge and compare every lane against the model.
    task automatic tick();
        @(negedge ck);
        lane_check("l1", bus1.O, bus1.fin, bus1.busy, 0);
        lane_check("l2", bus2.O, bus2.fin, bus2.busy, 1);
        lane_check("l4", bus4.O, bus4.fin, bus4.busy, 2);
    endtask

    task automatic all_zero();
        lane_zero("l1", bus1.O, bus1.fin, bus1.busy);
        lane_zero("l2", bus2.O, bus2.fin, bus2.busy);
        lane_zero("l4", bus4.O, bus4.fin, bus4.busy);
    endtask

    // Single-cycle start, then wait out the slowest lane; checks latency and optionally O.
    task automatic op(input logic s, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] lit, input bit use_lit);
        int lat [3];
        lat = '{0, 0, 0};
        sgn = s; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (bus1.fin && lat[0] == 0) lat[0] = c;
            if (bus2.fin && lat[1] == 0) lat[1] = c;
            if (bus4.fin && lat[2] == 0) lat[2] = c;
        end
        check("lat_l1", 32'(lat[0]), 32'd9);
        check("lat_l2", 32'(lat[1]), 32'd5);
        check("lat_l4", 32'(lat[2]), 32'd3);
        if (use_lit) begin
            check("lit_l1", 32'(bus1.O), 32'(lit));
            check("lit_l2", 32'(bus2.O), 32'(lit));
            check("lit_l4", 32'(bus4.O), 32'(lit));
        end
    endtask

    initial begin
        int f1;
        int f2;
        int f4;

        #1 rst = 1'b1;
        #1 all_zero();
        tick();
        tick();
        rst = 1'b0;

        // Directed values with hand-computed products.
        op(1'b0, 8'd255, 8'd255, 16'hFE01, 1'b1);
        op(1'b1, 8'h80,  8'h80,  16'h4000, 1'b1);
        op(1'b1, 8'hFF,  8'h05,  16'hFFFB, 1'b1);
        op(1'b1, 8'h80,  8'h7F,  16'hC080, 1'b1);
        op(1'b0, 8'd200, 8'd123, 16'd24600, 1'b1);
        op(1'b0, 8'd0,   8'd173, 16'd0,    1'b1);
        op(1'b1, 8'h7F,  8'h7F,  16'h3F01, 1'b1);
        op(1'b1, 8'h80,  8'h01,  16'hFF80, 1'b1);
        op(1'b0, 8'h80,  8'h80,  16'h4000, 1'b1);

        // Random isolated operations.
        for (int i = 0; i < 150; i++) begin
            op(1'($urandom), 8'($urandom), 8'($urandom), 16'd0, 1'b0);
        end

        // start while busy: lane BPC=4 is finishing on that edge and accepts it.
        sgn = 1'b0; a = 8'd3; b = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        f1 = 0; f2 = 0; f4 = 0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 3) begin a = 8'd9; b = 8'd9; start = 1'b1; end
            tick();
            if (c == 3) start = 1'b0;
            f1 += int'(bus1.fin); f2 += int'(bus2.fin); f4 += int'(bus4.fin);
        end
        check("busy_fins_l1", 32'(f1), 32'd1);
        check("busy_fins_l2", 32'(f2), 32'd1);
        check("busy_fins_l4", 32'(f4), 32'd2);
        check("busy_O_l1", 32'(bus1.O), 32'd12);
        check("busy_O_l2", 32'(bus2.O), 32'd12);
        check("busy_O_l4", 32'(bus4.O), 32'd81);

        // Back-to-back: start held, operands change every cycle.
        start = 1'b1;
        f1 = 0; f2 = 0; f4 = 0;
        for (int c = 1; c <= 91; c++) begin
            sgn = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            tick();
            f1 += int'(bus1.fin); f2 += int'(bus2.fin); f4 += int'(bus4.fin);
        end
        check("b2b_fins_l1", 32'(f1), 32'd10);
        check("b2b_fins_l2", 32'(f2), 32'd18);
        check("b2b_fins_l4", 32'(f4), 32'd30);
        for (int c = 0; c < 2000; c++) begin
            sgn = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            tick();
        end
        start = 1'b0;
        for (int c = 0; c < 12; c++) tick();

        // Reset in the middle of an operation takes effect without a clock edge.
        sgn = 1'b0; a = 8'd100; b = 8'd50; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) tick();
        #2 rst = 1'b1;
        #1 all_zero();
        tick();
        tick();
        rst = 1'b0;
        f1 = 0; f2 = 0; f4 = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            f1 += int'(bus1.fin); f2 += int'(bus2.fin); f4 += int'(bus4.fin);
        end
        check("rst_nofin_l1", 32'(f1), 32'd0);
        check("rst_nofin_l2", 32'(f2), 32'd0);
        check("rst_nofin_l4", 32'(f4), 32'd0);
        op(1'b1, 8'hFB, 8'h07, 16'hFFDD, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
